reg_bus_file: RTL and testbench

- Datapath stage directly downstream of control_unit.
- Consumes its mov_enable / reg_addr_from / reg_addr_to / operand strobes and performs one register-to-register transfer per enabled cycle.
- Holds the 16-entry register file, the virtual input register (0xA), the ALU with its virtual result register (0xD), a flag register, and a handshaked output port (0xE).

---
 rtl/reg_bus_file.sv | 71 +++++++
 tb/tb_reg_bus_file.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_bus_file.sv
// reg_bus_file: 16-entry register file with virtual input (0xA), ALU result (0xD), flags and handshaked output port (0xE).
// Optional debug read port enabled by defining REG_DBG_PORT_EN.
module reg_bus_file #(
    parameter int DATA_W = 16,
    parameter logic [3:0] FLAG_ADDR = 4'hf
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mov_enable,
    input  logic [3:0]        reg_addr_from,
    input  logic [3:0]        reg_addr_to,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_overrun,
    output logic [2:0]        flags
`ifdef REG_DBG_PORT_EN
    ,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
`endif
);
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W:0]   alu_wide;
    logic [DATA_W-1:0] alu_res, src;
    logic [2:0]        alu_flags;
    logic              wr, wr_e;
    // Bit DATA_W of the 17-bit result is carry for add, borrow for sub, 0 otherwise.
    always_comb begin
        case (operand[3:0])
            4'd0:    alu_wide = {1'b0, regs[11]} + {1'b0, regs[12]};
            4'd1:    alu_wide = {1'b0, regs[11]} - {1'b0, regs[12]};
            4'd2:    alu_wide = {1'b0, regs[11] & regs[12]};
            4'd3:    alu_wide = {1'b0, regs[11] | regs[12]};
            4'd4:    alu_wide = {1'b0, regs[11] ^ regs[12]};
            4'd5:    alu_wide = {1'b0, ~regs[11]};
            default: alu_wide = {1'b0, regs[11]};
        endcase
    end
    assign alu_res   = alu_wide[DATA_W-1:0];
    assign alu_flags = {alu_res[DATA_W-1], alu_wide[DATA_W], alu_res == '0};
    assign src = reg_addr_from == 4'ha      ? operand :
                 reg_addr_from == 4'hd      ? alu_res :
                 reg_addr_from == 4'he      ? out_data :
                 reg_addr_from == FLAG_ADDR ? {{(DATA_W-3){1'b0}}, flags} :
                 regs[reg_addr_from];
    assign wr   = mov_enable && reg_addr_to != 4'ha && reg_addr_to != 4'hd && reg_addr_to != FLAG_ADDR;
    assign wr_e = wr && reg_addr_to == 4'he;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_overrun <= 1'b0;
            flags       <= '0;
        end else begin
            if (wr && !wr_e) regs[reg_addr_to] <= src;
            if (wr_e) out_data <= src;
            out_valid <= wr_e ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
            if (wr_e && out_valid && !out_ready) out_overrun <= 1'b1;
            if (mov_enable && reg_addr_from == 4'hd) flags <= alu_flags;
        end
    end
`ifdef REG_DBG_PORT_EN
    assign dbg_data = (dbg_addr == 4'ha || dbg_addr == 4'hd) ? '0 :
                      dbg_addr == FLAG_ADDR ? {{(DATA_W-3){1'b0}}, flags} :
                      dbg_addr == 4'he ? out_data :
                      regs[dbg_addr];
`endif
endmodule

// File: tb/tb_reg_bus_file.sv
// tb_reg_bus_file: directed stimulus with an output-port scoreboard for reg_bus_file.
module tb_reg_bus_file;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mov_enable = 1'b0;
    logic [3:0]  reg_addr_from = '0;
    logic [3:0]  reg_addr_to = '0;
    logic [15:0] operand = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_overrun;
    logic [2:0]  flags;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q [$];

    reg_bus_file dut (
        .clk(clk), .rst(rst), .mov_enable(mov_enable), .reg_addr_from(reg_addr_from),
        .reg_addr_to(reg_addr_to), .operand(operand), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_overrun(out_overrun), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every consumed port value must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL port_unexpected: got %h expected nothing", out_data);
            end else begin
                chk("port_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic mov(input logic [3:0] f, input logic [3:0] t, input logic [15:0] op);
        mov_enable = 1'b1;
        reg_addr_from = f;
        reg_addr_to = t;
        operand = op;
        @(posedge clk);
        #1 mov_enable = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic read_reg(input logic [3:0] a, input logic [15:0] exp);
        exp_q.push_back(exp);
        mov(a, 4'he, 16'h0);
        consume();
    endtask

    task automatic read_alu(input logic [3:0] op, input logic [15:0] exp, input logic [2:0] exp_f);
        exp_q.push_back(exp);
        mov(4'hd, 4'he, {12'h0, op});
        chk("alu_flags", {13'b0, flags}, {13'b0, exp_f});
        consume();
    endtask

    logic [3:0]  alu_op [6] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    logic [15:0] alu_ex [6] = '{16'h0008, 16'h0001, 16'h0007, 16'h0006, 16'hFFFC, 16'h0003};
    logic [2:0]  alu_fl [6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mov_enable = 1'b1;
        reg_addr_from = 4'ha;
        reg_addr_to = 4'h3;
        operand = 16'h1234;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 mov_enable = 1'b0;
        #2 rst = 1'b0;
        chk("rst_valid", {15'b0, out_valid}, 16'h0);
        chk("rst_overrun", {15'b0, out_overrun}, 16'h0);
        chk("rst_flags", {13'b0, flags}, 16'h0);
        chk("rst_data", out_data, 16'h0);
        @(posedge clk);
        #1 read_reg(4'h3, 16'h0000);

        mov(4'ha, 4'hb, 16'hFFFF);
        mov(4'ha, 4'hc, 16'h0001);
        mov(4'hd, 4'h5, 16'h0000);
        chk("add_carry_flags", {13'b0, flags}, {13'b0, 3'b011});
        read_reg(4'h5, 16'h0000);
        chk("flags_hold_after_mov", {13'b0, flags}, {13'b0, 3'b011});

        mov(4'ha, 4'hb, 16'h0003);
        mov(4'ha, 4'hc, 16'h0005);
        mov(4'hd, 4'h6, 16'h0001);
        chk("sub_borrow_flags", {13'b0, flags}, {13'b0, 3'b110});
        mov(4'h6, 4'h7, 16'h0000);
        chk("flags_unchanged", {13'b0, flags}, {13'b0, 3'b110});
        read_reg(4'h7, 16'hFFFE);
        read_reg(4'h6, 16'hFFFE);
        for (int i = 0; i < 6; i++) read_alu(alu_op[i], alu_ex[i], alu_fl[i]);

        mov(4'ha, 4'hd, 16'h5555);
        mov(4'ha, 4'hf, 16'h5555);
        chk("ro_flags", {13'b0, flags}, 16'h0000);
        chk("ro_valid", {15'b0, out_valid}, 16'h0);
        read_reg(4'hf, 16'h0000);
        read_reg(4'hb, 16'h0003);
        read_reg(4'hc, 16'h0005);

        mov(4'ha, 4'he, 16'h0011);
        chk("load_valid", {15'b0, out_valid}, 16'h1);
        chk("load_data", out_data, 16'h0011);
        exp_q.push_back(16'h0011);
        exp_q.push_back(16'h0022);
        out_ready = 1'b1;
        mov(4'ha, 4'he, 16'h0022);
        chk("hs_write_data", out_data, 16'h0022);
        chk("hs_write_valid", {15'b0, out_valid}, 16'h1);
        chk("hs_write_overrun", {15'b0, out_overrun}, 16'h0);
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("hs_drain_valid", {15'b0, out_valid}, 16'h0);

        mov(4'ha, 4'he, 16'h00AA);
        chk("ovr_first_valid", {15'b0, out_valid}, 16'h1);
        chk("ovr_first_data", out_data, 16'h00AA);
        chk("ovr_first_flag", {15'b0, out_overrun}, 16'h0);
        mov(4'ha, 4'he, 16'h00BB);
        chk("ovr_second_data", out_data, 16'h00BB);
        chk("ovr_second_flag", {15'b0, out_overrun}, 16'h1);
        exp_q.push_back(16'h00BB);
        consume();
        chk("ovr_sticky", {15'b0, out_overrun}, 16'h1);
        chk("ovr_drain_valid", {15'b0, out_valid}, 16'h0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
